warp_rr_arbiter: RTL
====================

# warp_rr_arbiter

Parametrised round-robin arbiter that selects one of `NUM_REQ` warps per cycle for issue inside an SM. It generalises the fixed 4-warp rotation to any requester count and adds a valid/ready grant handshake with grant hold under back-pressure. It also supports optional burst retention, which keeps the same warp granted for up to `MAX_BURST` consecutive accepted issues. It sits between the per-warp ready logic and the instruction issue stage.

## Interface
- `NUM_REQ`, default `NUM_WARPS_PER_SM`: number of requesters; must be ≥2.
- `MAX_BURST`, default 4: maximum consecutive accepted grants to one requester when bursting is enabled; must be ≥1.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  NUM_REQ  per-warp request; once asserted, a request stays high until its grant is accepted.
- `grant_ready`  in  1  issue stage accepts the current grant this cycle.
- `grantOH`  out  NUM_REQ  one-hot grant; all zero when `grant_valid` is 0.
- `grant_valid`  out  1  a grant is presented.
- `grant_idx`  out  $clog2(NUM_REQ)  binary index of the granted warp; 0 when not valid.

## Operation
- State registers:
  - `last_idx`: index of the last accepted requester.
  - `hold`: 1 bit; a grant is outstanding and frozen.
  - `held_oh`: NUM_REQ bits; the frozen grant.
  - `burst_cnt`: $clog2(MAX_BURST+1) bits.
- Reset values:
  - `last_idx` = NUM_REQ-1, so requester 0 has top priority after reset.
  - `hold` = 0, `held_oh` = 0, `burst_cnt` = 0.
  - Outputs `grantOH` = 0, `grant_valid` = 0, `grant_idx` = 0 while `reset` is high.
- Two-state FSM:
  - ARB (`hold` = 0): the grant is computed combinationally from `request` and `last_idx`. The first set bit scanning `last_idx`+1, +2, …, wrapping modulo NUM_REQ, ends at `last_idx` itself. `grant_valid` = |request.
  - HOLD (`hold` = 1): `grantOH` = `held_oh`, `grant_valid` = 1, and `request` changes are ignored.
- Transitions:
  - ARB→HOLD when `grant_valid` && !`grant_ready`; capture `held_oh` = `grantOH`.
  - HOLD→ARB when `grant_ready`.
  - ARB→ARB on acceptance or when there is no request.
- On acceptance (`grant_valid` && `grant_ready`):
  - `last_idx` ← `grant_idx`.
  - `burst_cnt` ← `burst_cnt`+1 if the grant goes to the same index as the previous acceptance, else 1.
- A single requester requesting continuously is granted every cycle. Wrap-around from NUM_REQ-1 to 0 follows the modulo rule.
- Request dropped during HOLD is a protocol violation. The grant is still held; with assertions enabled, an assertion fires.

## Timing
- Zero-cycle arbitration latency: in ARB, `grantOH` is valid in the same cycle `request` rises.
- The pointer, hold and burst updates take effect in the cycle after the accepting edge.
- Under back-pressure, the grant stays bit-identical every cycle until the cycle in which `grant_ready` = 1. It then re-arbitrates combinationally in the following cycle.
- `reset` asserted mid-HOLD drops the grant in the same cycle and restores the reset state at the next edge.
- `grant_ready` with `grant_valid` = 0 has no effect.

## Configuration
- `WARP_ARB_BURST_EN` defined: bursting is enabled.
  - If the last accepted requester still requests and `burst_cnt` < MAX_BURST, it is granted again ahead of the rotation.
  - When `burst_cnt` = MAX_BURST, rotation resumes from `last_idx`+1.
- `WARP_ARB_BURST_EN` undefined:
  - `burst_cnt` is not built.
  - The pointer always advances past the accepted requester (pure round-robin).

## Structure
- Package `defines`:
  - Provides `NUM_WARPS_PER_SM`.
  - Add `warp_idx_t` (logic[$clog2(NUM_WARPS_PER_SM)-1:0]) and `WARP_ARB_MAX_BURST` default 4.
- Sub-module `rr_priority_select`:
  - Purely combinational.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant, binary index and any-valid.
  - Implemented by a double-width rotate and priority encode.
- The top level holds the FSM, the pointer, the hold register and the burst counter.

## Test plan
- Reset, NUM_REQ=4, `request`=4'b1111, `grant_ready`=1 for 5 cycles -> `grant_idx` sequence 0,1,2,3,0 (burst off).
- `request`=4'b1010 after `last_idx`=3 -> grant 1, then 3, then 1; indices 0 and 2 are never granted.
- Grant idx 2 with `grant_ready`=0 for 3 cycles while `request` changes to 4'b0111 -> `grantOH` stays 4'b0100. Accept on the 4th cycle; the next grant is idx 0.
- `WARP_ARB_BURST_EN`, MAX_BURST=2, `request`=4'b0011, `grant_ready`=1 -> idx 0,0,1,1,0,0.
- `reset` asserted during HOLD on idx 3 -> `grant_valid`=0 that cycle. With `request`=4'b1001 after reset, idx 0 is granted first.
- NUM_REQ=8, only `request[7]` high, then only `request[0]` -> grants 7 then 0 (wrap-around); `grant_idx` width 3.

Source files
------------

// File: rtl/defines.sv
// Shared SM-level definitions for the warp issue arbiter.
// Optional feature macro: WARP_ARB_BURST_EN (burst retention).
package defines;

  localparam int NUM_WARPS_PER_SM   = 4;
  localparam int WARP_ARB_MAX_BURST = 4;

  typedef logic [$clog2(NUM_WARPS_PER_SM)-1:0] warp_idx_t;

  // ARB: grant follows the requests; HOLD: grant frozen until accepted
  typedef enum logic {
    ARB_S  = 1'b0,
    HOLD_S = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating priority select: scans the request vector starting
// at i_start, wrapping modulo N, and returns the first set requester.
module rr_priority_select #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_grant_oh,
  output logic [W-1:0] o_grant_idx,
  output logic         o_valid
);

  logic [N-1:0] w_rot;
  logic [W:0]   w_off;
  logic [W:0]   w_sum;

  // Rotate so i_start lands at bit 0, find lowest set bit, map back to index
  always_comb begin
    w_rot = N'({i_req, i_req} >> i_start);
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_off = w_rot[i] ? (W+1)'(i) : w_off;
    end
    w_sum = {1'b0, i_start} + w_off;
    if (w_sum >= (W+1)'(N)) begin
      w_sum = w_sum - (W+1)'(N);
    end else begin
      w_sum = w_sum;
    end
    o_valid = |i_req;
    if (o_valid) begin
      o_grant_idx = w_sum[W-1:0];
      o_grant_oh  = N'(1) << w_sum[W-1:0];
    end else begin
      o_grant_idx = '0;
      o_grant_oh  = '0;
    end
  end

endmodule

// File: rtl/warp_rr_arbiter_chk.sv
// Protocol checker: a requester whose grant is frozen must keep requesting.
module warp_rr_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  input logic               i_hold,
  input logic [NUM_REQ-1:0] i_held_oh,
  input logic [NUM_REQ-1:0] i_request
);

  a_req_kept_in_hold: assert property (
    @(posedge i_clk) disable iff (i_reset)
    i_hold |-> ((i_request & i_held_oh) == i_held_oh)
  );

endmodule

// File: rtl/warp_rr_arbiter.sv
// Round-robin warp issue arbiter with valid/ready grant hold.
// Optional feature macro: WARP_ARB_BURST_EN keeps the last accepted warp
// granted for up to MAX_BURST consecutive accepted issues.
module warp_rr_arbiter
  import defines::*;
#(
  parameter  int NUM_REQ   = NUM_WARPS_PER_SM,
  parameter  int MAX_BURST = WARP_ARB_MAX_BURST,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic               grant_ready,
  output logic [NUM_REQ-1:0] grantOH,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_last_idx;
  logic [NUM_REQ-1:0] r_held_oh;
  logic [IDX_W-1:0]   w_next_idx;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_held_idx;
  logic [NUM_REQ-1:0] w_arb_oh;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_accept;
  logic               w_capture;

  assign w_next_idx = (r_last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_last_idx + IDX_W'(1);
  assign w_accept   = grant_valid && grant_ready;
  assign w_capture  = (r_state == ARB_S) && w_arb_valid && !grant_ready;

`ifdef WARP_ARB_BURST_EN
  logic [CNT_W-1:0] r_burst_cnt;

  // Scan start: stay on the last accepted warp while its burst budget lasts
  always_comb begin
    if ((r_burst_cnt != CNT_W'(0)) && (r_burst_cnt < CNT_W'(MAX_BURST)) && request[r_last_idx]) begin
      w_start = r_last_idx;
    end else begin
      w_start = w_next_idx;
    end
  end

  // Burst counter: zero means no acceptance since reset; saturates at MAX_BURST
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      if ((r_burst_cnt != CNT_W'(0)) && (grant_idx == r_last_idx)) begin
        r_burst_cnt <= (r_burst_cnt == CNT_W'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
      end else begin
        r_burst_cnt <= CNT_W'(1);
      end
    end else begin
      r_burst_cnt <= r_burst_cnt;
    end
  end
`else
  // Pure round-robin: always scan from the warp after the last accepted one
  always_comb begin
    w_start = w_next_idx;
  end
`endif

  rr_priority_select #(
    .N (NUM_REQ)
  ) u_sel (
    .i_req       (request),
    .i_start     (w_start),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_valid     (w_arb_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: freeze an unaccepted grant, release it once accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_S:   w_state_nxt = w_capture ? HOLD_S : ARB_S;
      HOLD_S:  w_state_nxt = grant_ready ? ARB_S : HOLD_S;
      default: w_state_nxt = ARB_S;
    endcase
  end

  // Pointer and frozen-grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_idx <= IDX_W'(NUM_REQ - 1);
      r_held_oh  <= '0;
    end else begin
      r_last_idx <= w_accept ? grant_idx : r_last_idx;
      r_held_oh  <= w_capture ? w_arb_oh : r_held_oh;
    end
  end

  // Binary index of the frozen one-hot grant
  always_comb begin
    w_held_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_held_idx = w_held_idx | (r_held_oh[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  // Outputs: reset drops the grant immediately; HOLD presents the frozen grant
  always_comb begin
    grantOH     = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (reset) begin
      grantOH     = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
    end else begin
      case (r_state)
        ARB_S: begin
          grantOH     = w_arb_oh;
          grant_valid = w_arb_valid;
          grant_idx   = w_arb_idx;
        end
        HOLD_S: begin
          grantOH     = r_held_oh;
          grant_valid = 1'b1;
          grant_idx   = w_held_idx;
        end
        default: begin
          grantOH     = '0;
          grant_valid = 1'b0;
          grant_idx   = '0;
        end
      endcase
    end
  end

  warp_rr_arbiter_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_hold    (r_state == HOLD_S),
    .i_held_oh (r_held_oh),
    .i_request (request)
  );

endmodule
